reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sync.sv | 21 ++
 rtl/reset_sequencer.sv | 119 +++++++++++
 tb/tb_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default timing for the reset sequencer and its helpers.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int unsigned DEF_STAGES      = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_STAGE_DELAY = 8;
    localparam int unsigned DEF_CNT_W       = 16;

    // Wide enough to count 0..8 released stages.
    localparam int unsigned IDX_W = 4;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clk edge.
module reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic sync_ok
);

    logic meta;

    // Shift a constant 1 through two flops once rst_n is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync_ok <= 1'b0;
        end else begin
            meta    <= 1'b1;
            sync_ok <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all outputs, then drop them one by one in index order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned STAGES      = DEF_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_req,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [2:0]        stage_idx
);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [STAGES-1:0]  rst_nxt;
    logic               ready_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               sync_ok;

    reset_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_ok (sync_ok)
    );

    // Status output carries the low bits of the released-stage count.
    assign stage_idx = idx_q[2:0];

    // State and output registers, all forced to the reset state by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            rst_out <= rst_nxt;
            ready   <= ready_nxt;
            idx_q   <= idx_nxt;
        end
    end

    // Next-state and next-output logic; releases shift a zero in from bit 0.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        rst_nxt   = rst_out;
        ready_nxt = ready;
        idx_nxt   = idx_q;

        case (state_q)
            ST_ASSERT: begin
                if (sync_ok) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_nxt = '0;
                    rst_nxt = rst_out << 1;
                    idx_nxt = IDX_W'(1);
                    if (STAGES == 1) begin
                        state_nxt = ST_DONE;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (soft_rst_req) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    idx_nxt   = '0;
                end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    cnt_nxt = '0;
                    rst_nxt = rst_out << 1;
                    idx_nxt = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(STAGES - 1)) begin
                        state_nxt = ST_DONE;
                        ready_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (soft_rst_req) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    idx_nxt   = '0;
                end
            end

            default: begin
                state_nxt = ST_ASSERT;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: table-driven timing checks, corner sequences, randomized run vs elapsed-time model.
module tb_reset_sequencer;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       soft_rst_req = 1'b0;

    logic [3:0] rst_out0;
    logic       ready0;
    logic [2:0] idx0;
    logic [0:0] rst_out1;
    logic       ready1;
    logic [2:0] idx1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ecount    = 0;

    // Model: edges since the sequence (re)entered its hold phase; -1 while not started.
    int e0 = -1, hi0 = 0;
    int e1 = -1, hi1 = 0;

    always #5 clk = ~clk;

    reset_sequencer dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out0),
        .ready        (ready0),
        .stage_idx    (idx0)
    );

    reset_sequencer #(
        .STAGES      (1),
        .HOLD_CYCLES (1),
        .STAGE_DELAY (1),
        .CNT_W       (4)
    ) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out1),
        .ready        (ready1),
        .stage_idx    (idx1)
    );

    // Number of released stages after e edges of the sequence.
    function automatic int rel_n(int e, int st, int h, int d);
        int n;
        if (e < h) return 0;
        n = 1 + (e - h) / d;
        if (n > st) n = st;
        return n;
    endfunction

    // Reference for the default instance: hold entered on the third edge with rst_n high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= -1;
            hi0 <= 0;
        end else if (e0 >= 0) begin
            e0 <= (soft_rst_req && rel_n(e0, 4, 16, 8) >= 1) ? 0 : e0 + 1;
        end else begin
            hi0 <= hi0 + 1;
            if (hi0 == 2) e0 <= 0;
        end
    end

    // Reference for the single-stage instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1  <= -1;
            hi1 <= 0;
        end else if (e1 >= 0) begin
            e1 <= (soft_rst_req && rel_n(e1, 1, 1, 1) >= 1) ? 0 : e1 + 1;
        end else begin
            hi1 <= hi1 + 1;
            if (hi1 == 2) e1 <= 0;
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @edge %0d: got %h want %h", name, ecount, act, exp);
    endtask

    task automatic check_model();
        int n0, n1;
        logic [3:0] m;
        n0 = rel_n(e0, 4, 16, 8);
        n1 = rel_n(e1, 1, 1, 1);
        m  = 4'hF;
        m  = m << n0;
        cmp("model0", {rst_out0, ready0, idx0}, {m, (n0 == 4), 3'(n0)});
        cmp("model1", {3'b000, rst_out1, ready1, idx1}, {3'b000, (n1 == 0), (n1 == 1), 3'(n1)});
    endtask

    task automatic check0(input string name, input logic [3:0] r, input logic rd, input logic [2:0] i);
        cmp(name, {rst_out0, ready0, idx0}, {r, rd, i});
    endtask

    task automatic check1(input string name, input logic r, input logic rd, input logic [2:0] i);
        cmp(name, {3'b000, rst_out1, ready1, idx1}, {3'b000, r, rd, i});
    endtask

    // One clock: advance the edge count and check both instances on the falling edge.
    task automatic step();
        @(posedge clk);
        ecount++;
        @(negedge clk);
        check_model();
    endtask

    task automatic step_to(input int k);
        while (ecount < k) step();
    endtask

    // Called on a falling edge: the next rising edge becomes E0.
    task automatic release_rst();
        rst_n  = 1'b1;
        ecount = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) step();
        release_rst();
    endtask

    typedef struct {
        int         edge_n;
        logic [3:0] r;
        logic       rd;
        logic [2:0] i;
        logic       r1;
        logic       rd1;
        logic [2:0] i1;
    } row_t;

    row_t tbl[12];

    task automatic run_table(input string tag);
        for (int k = 0; k < 12; k++) begin
            step_to(tbl[k].edge_n);
            check0({tag, "_d0"}, tbl[k].r, tbl[k].rd, tbl[k].i);
            check1({tag, "_d1"}, tbl[k].r1, tbl[k].rd1, tbl[k].i1);
        end
    endtask

    initial begin
        int lowcnt;
        int dens;

        tbl[0]  = '{0,  4'b1111, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{2,  4'b1111, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{3,  4'b1111, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1};
        tbl[3]  = '{17, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1};
        tbl[4]  = '{18, 4'b1110, 1'b0, 3'd1, 1'b0, 1'b1, 3'd1};
        tbl[5]  = '{25, 4'b1110, 1'b0, 3'd1, 1'b0, 1'b1, 3'd1};
        tbl[6]  = '{26, 4'b1100, 1'b0, 3'd2, 1'b0, 1'b1, 3'd1};
        tbl[7]  = '{33, 4'b1100, 1'b0, 3'd2, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{34, 4'b1000, 1'b0, 3'd3, 1'b0, 1'b1, 3'd1};
        tbl[9]  = '{41, 4'b1000, 1'b0, 3'd3, 1'b0, 1'b1, 3'd1};
        tbl[10] = '{42, 4'b0000, 1'b1, 3'd4, 1'b0, 1'b1, 3'd1};
        tbl[11] = '{50, 4'b0000, 1'b1, 3'd4, 1'b0, 1'b1, 3'd1};

        // Power-up.
        repeat (5) @(negedge clk);
        check0("por_d0", 4'b1111, 1'b0, 3'd0);
        check1("por_d1", 1'b1, 1'b0, 3'd0);
        release_rst();
        run_table("pwrup");

        // Asynchronous assertion while DONE, observed before the next clock edge.
        #2 rst_n = 1'b0;
        #1;
        check0("async_done_d0", 4'b1111, 1'b0, 3'd0);
        check1("async_done_d1", 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        step();
        release_rst();
        run_table("after_async");

        // Soft reset pulse in DONE at edge S = 51.
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check0("soft_S", 4'b1111, 1'b0, 3'd0);
        check1("soft_S_d1", 1'b1, 1'b0, 3'd0);
        step_to(66);
        check0("soft_S15", 4'b1111, 1'b0, 3'd0);
        step_to(67);
        check0("soft_S16", 4'b1110, 1'b0, 3'd1);
        step_to(90);
        check0("soft_S39", 4'b1000, 1'b0, 3'd3);
        step_to(91);
        check0("soft_S40", 4'b0000, 1'b1, 3'd4);

        // Reset mid-RELEASE, just after 4'b1100 appears.
        do_reset();
        step_to(26);
        check0("mid_rel_pre", 4'b1100, 1'b0, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check0("mid_rel_async", 4'b1111, 1'b0, 3'd0);
        @(negedge clk);
        step();
        release_rst();
        run_table("mid_rel");

        // Soft pulse sampled in HOLD is ignored.
        do_reset();
        step_to(4);
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        step_to(17);
        check0("hold_pulse_17", 4'b1111, 1'b0, 3'd0);
        step_to(18);
        check0("hold_pulse_18", 4'b1110, 1'b0, 3'd1);

        // Request held high E5..E20: honoured at E19 once release has begun.
        do_reset();
        step_to(4);
        soft_rst_req = 1'b1;
        step_to(18);
        check0("held_18", 4'b1110, 1'b0, 3'd1);
        step_to(19);
        check0("held_19", 4'b1111, 1'b0, 3'd0);
        step_to(20);
        soft_rst_req = 1'b0;
        step_to(34);
        check0("held_34", 4'b1111, 1'b0, 3'd0);
        step_to(35);
        check0("held_35", 4'b1110, 1'b0, 3'd1);

        // Randomized soft requests and reset pulses against the model.
        lowcnt = 0;
        dens   = 63;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) dens = (dens == 63) ? 7 : 63;
            soft_rst_req = ($urandom_range(dens) == 0);
            if (lowcnt > 0) begin
                lowcnt--;
                if (lowcnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(300) == 0) begin
                rst_n  = 1'b0;
                lowcnt = $urandom_range(3, 1);
            end
            step();
        end
        soft_rst_req = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
